// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Port 0 is the core MEM stage, port 1 the secondary master (DMA/debug).
// One transaction at a time: IDLE (grant) -> ACCESS (one memory cycle) ->
// RESP (one-cycle response pulse to the owner). Misaligned or reserved-size
// requests skip ACCESS and answer with an error straight from IDLE.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  p0_req_valid_i,
  output logic                  p0_req_ready_o,
  input  logic                  p0_write_en_i,
  input  logic [1:0]            p0_mem_type_i,
  input  logic                  p0_mem_sign_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [ADDR_WIDTH-1:0] p0_write_data_i,
  output logic                  p0_rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] p0_rsp_data_o,
  output logic                  p0_rsp_err_o,
  input  logic                  p1_req_valid_i,
  output logic                  p1_req_ready_o,
  input  logic                  p1_write_en_i,
  input  logic [1:0]            p1_mem_type_i,
  input  logic                  p1_mem_sign_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [ADDR_WIDTH-1:0] p1_write_data_i,
  output logic                  p1_rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] p1_rsp_data_o,
  output logic                  p1_rsp_err_o,
  output logic                  mem_write_en_o,
  output logic [1:0]            mem_type_o,
  output logic                  mem_sign_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_write_data_o,
  input  logic [ADDR_WIDTH-1:0] mem_read_data_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q;
  logic                  we_q, sign_q;
  logic [1:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q, wdata_q;
  logic [ADDR_WIDTH-1:0] p0_rsp_data_q, p1_rsp_data_q;
  logic                  p0_rsp_err_q, p1_rsp_err_q;

  logic                  gnt0, gnt1, accept, sel;
  logic                  sel_we, sel_sign, sel_err;
  logic [1:0]            sel_type;
  logic [ADDR_WIDTH-1:0] sel_addr, sel_wdata;

  // Reserved size, or a half/word whose address is not naturally aligned.
  function automatic logic align_err(input logic [1:0] ty, input logic [1:0] a);
    return (ty == 2'b11) || (ty == 2'b01 && a[0]) || (ty == 2'b10 && a != 2'b00);
  endfunction

  // Round-robin grant: a lone requester wins; on a tie the port opposite last_grant wins.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (state_q == S_IDLE) begin
      gnt0 = p0_req_valid_i && (!p1_req_valid_i || last_grant_q);
      gnt1 = p1_req_valid_i && (!p0_req_valid_i || !last_grant_q);
    end
    accept    = gnt0 || gnt1;
    sel       = gnt1;
    sel_we    = sel ? p1_write_en_i   : p0_write_en_i;
    sel_type  = sel ? p1_mem_type_i   : p0_mem_type_i;
    sel_sign  = sel ? p1_mem_sign_i   : p0_mem_sign_i;
    sel_addr  = sel ? p1_addr_i       : p0_addr_i;
    sel_wdata = sel ? p1_write_data_i : p0_write_data_i;
    sel_err   = align_err(sel_type, sel_addr[1:0]);
  end

  assign p0_req_ready_o = gnt0;
  assign p1_req_ready_o = gnt1;

  // Next-state logic for the sequencer and the round-robin pointer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_grant_d = sel;
          state_d      = sel_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state; reset restarts in IDLE with port 0 favoured on the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (accept) owner_q <= sel;
    end
  end

  // Request latch; only consumed in ACCESS, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= sel_we;
      type_q  <= sel_type;
      sign_q  <= sel_sign;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Per-port response registers; they hold between responses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p0_rsp_data_q <= '0;
      p1_rsp_data_q <= '0;
      p0_rsp_err_q  <= 1'b0;
      p1_rsp_err_q  <= 1'b0;
    end else if (accept && sel_err) begin
      if (sel) begin
        p1_rsp_data_q <= '0;
        p1_rsp_err_q  <= 1'b1;
      end else begin
        p0_rsp_data_q <= '0;
        p0_rsp_err_q  <= 1'b1;
      end
    end else if (state_q == S_ACCESS) begin
      if (owner_q) begin
        p1_rsp_data_q <= we_q ? '0 : mem_read_data_i;
        p1_rsp_err_q  <= 1'b0;
      end else begin
        p0_rsp_data_q <= we_q ? '0 : mem_read_data_i;
        p0_rsp_err_q  <= 1'b0;
      end
    end
  end

  assign p0_rsp_valid_o = (state_q == S_RESP) && !owner_q;
  assign p1_rsp_valid_o = (state_q == S_RESP) && owner_q;
  assign p0_rsp_data_o  = p0_rsp_data_q;
  assign p1_rsp_data_o  = p1_rsp_data_q;
  assign p0_rsp_err_o   = p0_rsp_err_q;
  assign p1_rsp_err_o   = p1_rsp_err_q;

  assign mem_write_en_o   = (state_q == S_ACCESS) && we_q;
  assign mem_type_o       = (state_q == S_ACCESS) ? type_q  : 2'b00;
  assign mem_sign_o       = (state_q == S_ACCESS) && sign_q;
  assign mem_addr_o       = (state_q == S_ACCESS) ? addr_q  : '0;
  assign mem_write_data_o = (state_q == S_ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: 256-byte memory stub plus a byte-array
// reference model that predicts every response from the access rules.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        p0_req_valid_i = 0, p0_write_en_i = 0, p0_mem_sign_i = 0;
  logic [1:0]  p0_mem_type_i = 0;
  logic [31:0] p0_addr_i = 0, p0_write_data_i = 0;
  logic        p1_req_valid_i = 0, p1_write_en_i = 0, p1_mem_sign_i = 0;
  logic [1:0]  p1_mem_type_i = 0;
  logic [31:0] p1_addr_i = 0, p1_write_data_i = 0;
  logic        p0_req_ready_o, p0_rsp_valid_o, p0_rsp_err_o;
  logic        p1_req_ready_o, p1_rsp_valid_o, p1_rsp_err_o;
  logic [31:0] p0_rsp_data_o, p1_rsp_data_o;
  logic        mem_write_en_o, mem_sign_o;
  logic [1:0]  mem_type_o;
  logic [31:0] mem_addr_o, mem_write_data_o, mem_read_data_i;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;
  logic exp_last = 1'b1;       // last granted port, as the model sees it
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  data_mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .p0_req_valid_i(p0_req_valid_i), .p0_req_ready_o(p0_req_ready_o),
    .p0_write_en_i(p0_write_en_i), .p0_mem_type_i(p0_mem_type_i),
    .p0_mem_sign_i(p0_mem_sign_i), .p0_addr_i(p0_addr_i),
    .p0_write_data_i(p0_write_data_i), .p0_rsp_valid_o(p0_rsp_valid_o),
    .p0_rsp_data_o(p0_rsp_data_o), .p0_rsp_err_o(p0_rsp_err_o),
    .p1_req_valid_i(p1_req_valid_i), .p1_req_ready_o(p1_req_ready_o),
    .p1_write_en_i(p1_write_en_i), .p1_mem_type_i(p1_mem_type_i),
    .p1_mem_sign_i(p1_mem_sign_i), .p1_addr_i(p1_addr_i),
    .p1_write_data_i(p1_write_data_i), .p1_rsp_valid_o(p1_rsp_valid_o),
    .p1_rsp_data_o(p1_rsp_data_o), .p1_rsp_err_o(p1_rsp_err_o),
    .mem_write_en_o(mem_write_en_o), .mem_type_o(mem_type_o),
    .mem_sign_o(mem_sign_o), .mem_addr_o(mem_addr_o),
    .mem_write_data_o(mem_write_data_o), .mem_read_data_i(mem_read_data_i)
  );

  // Memory stub: combinational read of the driven address, writes on the clock edge.
  always_comb begin
    mem_read_data_i = 32'd0;
    case (mem_type_o)
      2'b00: mem_read_data_i = {{24{mem_sign_o & mem[mem_addr_o[7:0]][7]}}, mem[mem_addr_o[7:0]]};
      2'b01: mem_read_data_i = {{16{mem_sign_o & mem[mem_addr_o[7:0] + 8'd1][7]}},
                                mem[mem_addr_o[7:0] + 8'd1], mem[mem_addr_o[7:0]]};
      2'b10: mem_read_data_i = {mem[mem_addr_o[7:0] + 8'd3], mem[mem_addr_o[7:0] + 8'd2],
                                mem[mem_addr_o[7:0] + 8'd1], mem[mem_addr_o[7:0]]};
      default: mem_read_data_i = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write_en_o) begin
      mem[mem_addr_o[7:0]] <= mem_write_data_o[7:0];
      if (mem_type_o != 2'b00) mem[mem_addr_o[7:0] + 8'd1] <= mem_write_data_o[15:8];
      if (mem_type_o == 2'b10) begin
        mem[mem_addr_o[7:0] + 8'd2] <= mem_write_data_o[23:16];
        mem[mem_addr_o[7:0] + 8'd3] <= mem_write_data_o[31:24];
      end
    end
  end

  // Reference model: error rule, then byte-wise store or little-endian load.
  function automatic void predict(input logic we, input logic [1:0] ty, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] data);
    int nb;
    logic [31:0] v;
    err  = (ty == 2'd3) || (ty == 2'd1 && a[0]) || (ty == 2'd2 && a[1:0] != 2'd0);
    data = 32'd0;
    if (err) return;
    nb = (ty == 2'd0) ? 1 : (ty == 2'd1) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'((a + 32'(i)) % 256)] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'((a + 32'(i)) % 256)]) << (8 * i));
      if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      data = v;
    end
  endfunction

  function automatic logic rdy(input int port);
    return (port == 0) ? p0_req_ready_o : p1_req_ready_o;
  endfunction
  function automatic logic rvld(input int port);
    return (port == 0) ? p0_rsp_valid_o : p1_rsp_valid_o;
  endfunction
  function automatic logic [31:0] rdat(input int port);
    return (port == 0) ? p0_rsp_data_o : p1_rsp_data_o;
  endfunction
  function automatic logic rerr(input int port);
    return (port == 0) ? p0_rsp_err_o : p1_rsp_err_o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic we, input logic [1:0] ty,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid_i = v; p0_write_en_i = we; p0_mem_type_i = ty;
      p0_mem_sign_i = sg; p0_addr_i = a; p0_write_data_i = wd;
    end else begin
      p1_req_valid_i = v; p1_write_en_i = we; p1_mem_type_i = ty;
      p1_mem_sign_i = sg; p1_addr_i = a; p1_write_data_i = wd;
    end
  endtask

  // Bounded wait until the given port sees ready; a timeout counts as a failure.
  task automatic wait_ready(input int port, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy(port)) begin ok = 1'b1; break; end
      tick(); settle();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_ready p%0d: ready=0 required=1 within 20 cycles", port); end
  endtask

  // Checks the cycles after an accept; entered settled in the cycle after the accept.
  task automatic run_post(input int port, input logic we, input logic [31:0] a,
                          input logic e_err, input logic [31:0] e_data);
    int oth;
    oth = 1 - port;
    checks++; if (p0_req_ready_o || p1_req_ready_o) begin errors++; $display("FAIL busy_ready1 p%0d: got %b%b required 00", port, p0_req_ready_o, p1_req_ready_o); end
    if (e_err) begin
      checks++; if (rvld(port) !== 1'b1) begin errors++; $display("FAIL err_rsp_valid p%0d: got %b required 1", port, rvld(port)); end
      checks++; if (rvld(oth) !== 1'b0) begin errors++; $display("FAIL err_other_valid p%0d: got %b required 0", oth, rvld(oth)); end
      checks++; if (rerr(port) !== 1'b1) begin errors++; $display("FAIL err_flag p%0d: got %b required 1", port, rerr(port)); end
      checks++; if (rdat(port) !== 32'd0) begin errors++; $display("FAIL err_data p%0d: got %h required 0", port, rdat(port)); end
      checks++; if (mem_write_en_o !== 1'b0) begin errors++; $display("FAIL err_no_write: got %b required 0", mem_write_en_o); end
    end else begin
      checks++; if (mem_write_en_o !== we) begin errors++; $display("FAIL access_we p%0d: got %b required %b", port, mem_write_en_o, we); end
      checks++; if (mem_addr_o !== a) begin errors++; $display("FAIL access_addr p%0d: got %h required %h", port, mem_addr_o, a); end
      checks++; if (p0_rsp_valid_o || p1_rsp_valid_o) begin errors++; $display("FAIL access_no_rsp: got %b%b required 00", p0_rsp_valid_o, p1_rsp_valid_o); end
      tick(); settle();
      checks++; if (p0_req_ready_o || p1_req_ready_o) begin errors++; $display("FAIL busy_ready2 p%0d: got %b%b required 00", port, p0_req_ready_o, p1_req_ready_o); end
      checks++; if (rvld(port) !== 1'b1) begin errors++; $display("FAIL rsp_valid p%0d: got %b required 1", port, rvld(port)); end
      checks++; if (rvld(oth) !== 1'b0) begin errors++; $display("FAIL other_valid p%0d: got %b required 0", oth, rvld(oth)); end
      checks++; if (rdat(port) !== e_data) begin errors++; $display("FAIL rsp_data p%0d addr %h: got %h required %h", port, a, rdat(port), e_data); end
      checks++; if (rerr(port) !== 1'b0) begin errors++; $display("FAIL rsp_err p%0d: got %b required 0", port, rerr(port)); end
      checks++; if (mem_write_en_o !== 1'b0) begin errors++; $display("FAIL resp_no_write: got %b required 0", mem_write_en_o); end
    end
  endtask

  // One single-port transaction, from request through response, then back to IDLE.
  task automatic run_txn(input int port, input logic we, input logic [1:0] ty, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    logic ok, e_err;
    logic [31:0] e_data;
    set_req(port, 1'b1, we, ty, sg, a, wd);
    settle();
    wait_ready(port, ok);
    if (ok) begin
      checks++; if (rdy(1 - port) !== 1'b0) begin errors++; $display("FAIL lone_ready p%0d: got 1 required 0", 1 - port); end
      predict(we, ty, sg, a, wd, e_err, e_data);
      exp_last = port[0];
      tick();
      set_req(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      settle();
      run_post(port, we, a, e_err, e_data);
    end else begin
      set_req(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    end
    tick(); settle();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick(); settle();
    checks++; if ({p0_req_ready_o, p1_req_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b required 00", p0_req_ready_o, p1_req_ready_o); end
    checks++; if ({p0_rsp_valid_o, p1_rsp_valid_o, p0_rsp_err_o, p1_rsp_err_o} !== 4'b0) begin errors++; $display("FAIL reset_rsp_flags: got %b%b%b%b required 0000", p0_rsp_valid_o, p1_rsp_valid_o, p0_rsp_err_o, p1_rsp_err_o); end
    checks++; if ({p0_rsp_data_o, p1_rsp_data_o} !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h %h required 0", p0_rsp_data_o, p1_rsp_data_o); end
    checks++; if ({mem_write_en_o, mem_type_o, mem_sign_o, mem_addr_o, mem_write_data_o} !== 68'd0) begin errors++; $display("FAIL reset_mem: got we=%b addr=%h wd=%h required 0", mem_write_en_o, mem_addr_o, mem_write_data_o); end
    rst_ni = 1'b1;
    exp_last = 1'b1;
    tick(); settle();
  endtask

  task automatic test_store_load();
    run_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (p0_rsp_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL store_load_hold: got %h required deadbeef", p0_rsp_data_o); end
  endtask

  task automatic test_fairness();
    logic ok, w, e_err;
    logic [31:0] e_data, a;
    run_txn(0, 1'b1, 2'b10, 1'b0, 32'h20, $urandom);
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h24, $urandom);
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    settle();
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (p0_req_ready_o || p1_req_ready_o) begin ok = 1'b1; break; end
        tick(); settle();
      end
      checks++; if (!ok) begin errors++; $display("FAIL fair_timeout k=%0d: no ready within 20 cycles", k); break; end
      w = ~exp_last;
      checks++; if ({p1_req_ready_o, p0_req_ready_o} !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_grant k=%0d: got p1/p0 ready %b%b required port %0d", k, p1_req_ready_o, p0_req_ready_o, w); end
      a = w ? 32'h24 : 32'h20;
      predict(1'b0, 2'b10, 1'b0, a, 32'h0, e_err, e_data);
      exp_last = w;
      tick();
      if (k == 3) begin
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      end
      settle();
      run_post(int'(w), 1'b0, a, e_err, e_data);
      tick(); settle();
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_misaligned();
    run_txn(1, 1'b1, 2'b01, 1'b0, 32'h3, $urandom);
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
  endtask

  task automatic test_reserved_and_sign();
    run_txn(0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    run_txn(1, 1'b1, 2'b00, 1'b0, 32'h41, 32'hABCDEF80);
    run_txn(1, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    checks++; if (p1_rsp_data_o !== 32'hFFFFFF80) begin errors++; $display("FAIL sign_byte: got %h required ffffff80", p1_rsp_data_o); end
    run_txn(1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
    run_txn(0, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
  endtask

  task automatic test_reset_mid();
    logic ok, e_err;
    logic [31:0] e_data;
    set_req(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
    settle();
    wait_ready(0, ok);
    predict(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, e_err, e_data);
    tick();
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    settle();
    checks++; if (mem_write_en_o !== 1'b1) begin errors++; $display("FAIL rstmid_access_we: got %b required 1", mem_write_en_o); end
    rst_ni = 1'b0;
    tick(); settle();
    checks++; if ({p0_rsp_valid_o, p1_rsp_valid_o, p0_req_ready_o, p1_req_ready_o} !== 4'b0) begin errors++; $display("FAIL rstmid_ctrl: got vld %b%b rdy %b%b required 0", p0_rsp_valid_o, p1_rsp_valid_o, p0_req_ready_o, p1_req_ready_o); end
    checks++; if ({p0_rsp_data_o, p1_rsp_data_o, p0_rsp_err_o, p1_rsp_err_o} !== 66'd0) begin errors++; $display("FAIL rstmid_rsp: got %h %h %b%b required 0", p0_rsp_data_o, p1_rsp_data_o, p0_rsp_err_o, p1_rsp_err_o); end
    checks++; if ({mem_write_en_o, mem_type_o, mem_sign_o, mem_addr_o, mem_write_data_o} !== 68'd0) begin errors++; $display("FAIL rstmid_mem: got we=%b addr=%h required 0", mem_write_en_o, mem_addr_o); end
    rst_ni = 1'b1;
    exp_last = 1'b1;
    tick(); settle();
    checks++; if (p0_rsp_valid_o || p1_rsp_valid_o) begin errors++; $display("FAIL rstmid_no_rsp: got %b%b required 00", p0_rsp_valid_o, p1_rsp_valid_o); end
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    settle();
    checks++; if ({p1_req_ready_o, p0_req_ready_o} !== 2'b01) begin errors++; $display("FAIL rstmid_first_grant: got p1/p0 ready %b%b required 01", p1_req_ready_o, p0_req_ready_o); end
    predict(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e_err, e_data);
    exp_last = 1'b0;
    tick();
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    settle();
    run_post(0, 1'b0, 32'h20, e_err, e_data);
    tick(); settle();
  endtask

  task automatic test_back_to_back();
    logic ok, e_err;
    logic [31:0] e_data;
    int prev;
    prev = 0;
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    settle();
    for (int k = 0; k < 3; k++) begin
      wait_ready(1, ok);
      if (!ok) break;
      if (k > 0) begin
        checks++; if (cycle_cnt - prev != 3) begin errors++; $display("FAIL b2b_spacing k=%0d: got %0d cycles required 3", k, cycle_cnt - prev); end
      end
      prev = cycle_cnt;
      predict(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, e_err, e_data);
      exp_last = 1'b1;
      tick();
      if (k == 2) set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      settle();
      run_post(1, 1'b0, 32'h44, e_err, e_data);
      tick(); settle();
    end
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_store_load();
    test_fairness();
    test_misaligned();
    test_reserved_and_sign();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the data memory subsystem.
- Port 0 is the core MEM stage; port 1 is the secondary master (DMA/debug loader).
- Accepts valid/ready requests, checks alignment, drives one memory access per transaction and returns a registered response to the owning port.
- Sits between the pipeline/loader and the data memory top-level.

Parameters:
- ADDR_WIDTH, 32, width of address and data buses.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- p0_req_valid_i  in  1  port 0 request valid.
- p0_req_ready_o  out  1  port 0 request accepted this cycle.
- p0_write_en_i  in  1  port 0: 1 = store, 0 = load.
- p0_mem_type_i  in  2  port 0 size: 00 byte, 01 half, 10 word, 11 reserved.
- p0_mem_sign_i  in  1  port 0 load sign-extend.
- p0_addr_i  in  ADDR_WIDTH  port 0 byte address.
- p0_write_data_i  in  ADDR_WIDTH  port 0 store data (LSB-aligned).
- p0_rsp_valid_o  out  1  port 0 response pulse.
- p0_rsp_data_o  out  ADDR_WIDTH  port 0 load data.
- p0_rsp_err_o  out  1  port 0 misaligned/reserved-type error.
- p1_*  (same ten signals as p0_*)  port 1.
- mem_write_en_o  out  1  to data memory.
- mem_type_o  out  2  to data memory.
- mem_sign_o  out  1  to data memory.
- mem_addr_o  out  ADDR_WIDTH  to data memory.
- mem_write_data_o  out  ADDR_WIDTH  to data memory.
- mem_read_data_i  in  ADDR_WIDTH  from data memory; combinational read of the driven address.

Behaviour:
- Reset (rst_ni low at a clock edge): state=IDLE, last_grant=1 (so port 0 wins first tie), all ready/rsp_valid/err outputs 0, rsp_data 0, all mem_* outputs 0.
- Reset mid-transaction discards the latched request; no response is issued and any memory write is suppressed from the next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - ready_o is combinational: asserted only for the port granted this cycle, only when state==IDLE.
  - Grant rules: only one port valid -> that port; both valid -> port opposite last_grant.
  - On valid&&ready: latch write_en/type/sign/addr/wdata and owner id; update last_grant; check alignment.
  - Error conditions: type 11; half with addr[0]=1; word with addr[1:0]!=0.
  - Error -> go to RESP with err flag set; no memory access.
  - OK -> go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_* outputs are driven from the latched request; mem_write_en_o equals the latched write_en.
  - Store commits at the ending clock edge.
  - mem_read_data_i is captured into the response data register (stores capture 0).
  - Next state RESP.
- RESP (1 cycle):
  - Owner's rsp_valid_o=1 with rsp_data_o/rsp_err_o; the other port's rsp_valid_o=0.
  - err=1 forces rsp_data_o=0.
  - Next state IDLE.
- Outside ACCESS, mem_write_en_o=0 and the other mem_* outputs hold 0.
- Latency: accept at cycle N, response at cycle N+2 (ok) or N+1 (error). Max throughput is one transaction per 3 cycles (per 2 on error).
- Requesters hold their request stable while valid and not ready. The arbiter never drops an accepted request.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1; neither port waits more than one transaction.
- rsp_data_o/rsp_err_o hold their last value outside RESP; only rsp_valid_o qualifies them.

Test Plan:
- Reset then p0 word store addr 0x10 data 0xDEADBEEF, then p0 word load 0x10 -> p0_req_ready_o high in IDLE cycle; mem_write_en_o high exactly one cycle; load response 2 cycles after accept with p0_rsp_data_o=0xDEADBEEF, err=0.
- Both ports valid continuously for 4 transactions (p0 load 0x20, p1 load 0x24) -> grant order p0,p1,p0,p1; p1_req_ready_o never high while p0 owns; each rsp_valid pulses only on its owner.
- p1 half store addr 0x0000_0003 -> no mem_write_en_o pulse; p1_rsp_valid_o one cycle after accept with p1_rsp_err_o=1, data 0; memory at 0x00 unchanged on readback.
- p0 mem_type 11 addr 0x40 -> error response; following p1 byte load 0x41 sign=1 after byte 0x80 stored -> p1_rsp_data_o=0xFFFFFF80, err=0.
- Assert rst_ni low during ACCESS of a p0 store to 0x30 -> no rsp_valid on either port; all outputs 0 next cycle; next first grant goes to p0 when both request.
- p1 only valid with p0 idle for 3 back-to-back loads -> p1 granted every IDLE cycle; accepts spaced exactly 3 cycles apart.
